// File: rtl/reset_combiner_n.sv
// Merges synchronised, maskable active-low reset sources and a software request
// into one registered AXI reset with minimum width, release hold-off and cause logging.
module reset_combiner_n #(
  parameter int NUM_SRC     = 2,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_ASSERT  = 4,
  parameter int HOLD_CYCLES = 8
) (
  input  logic               axi_aclk,
  input  logic               axi_aresetn,
  input  logic [NUM_SRC-1:0] src_aresetn,
  input  logic [NUM_SRC-1:0] src_mask,
  input  logic               sw_rst_req,
  input  logic               cause_clr,
  output logic               s_aresetn,
  output logic [1:0]         rst_state,
  output logic [NUM_SRC:0]   rst_cause,
  output logic [7:0]         rst_count
);

  localparam int ACW = $clog2(MIN_ASSERT + 1);
  localparam int HCW = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_ASSERT = 2'd0,
    ST_HOLD   = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  state_e                                state_q;
  logic                                  s_aresetn_q;
  logic [SYNC_STAGES-1:0][NUM_SRC-1:0]   sync_q;
  logic [ACW-1:0]                        asrt_cnt_q;
  logic [HCW-1:0]                        hold_cnt_q;
  logic [NUM_SRC:0]                      cause_q, cause_d;
  logic [7:0]                            count_q, count_d;

  logic [NUM_SRC-1:0] sync_out;
  logic               all_ok;
  logic               to_assert;
  logic               asrt_done;
  logic               hold_done;

  assign sync_out  = sync_q[SYNC_STAGES-1];
  // Masked sources are treated as permanently good; the mask is not registered.
  assign all_ok    = (&(sync_out | ~src_mask)) & ~sw_rst_req;
  assign to_assert = (state_q != ST_ASSERT) && !all_ok;
  assign asrt_done = (asrt_cnt_q >= ACW'(MIN_ASSERT - 1));
  assign hold_done = (hold_cnt_q == HCW'(HOLD_CYCLES - 1));

  always_comb begin
    cause_d = cause_clr ? '0 : cause_q;
    // Bits being set on this edge win over a simultaneous clear.
    if (to_assert) begin
      cause_d = cause_d | {sw_rst_req, (~sync_out & src_mask)};
    end
    count_d = count_q;
    if ((state_q == ST_RUN) && !all_ok && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state_q     <= ST_ASSERT;
      s_aresetn_q <= 1'b0;
      sync_q      <= '0;
      asrt_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      cause_q     <= '0;
      count_q     <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], src_aresetn};
      cause_q <= cause_d;
      count_q <= count_d;
      case (state_q)
        ST_ASSERT: begin
          if (asrt_cnt_q < ACW'(MIN_ASSERT)) begin
            asrt_cnt_q <= asrt_cnt_q + ACW'(1);
          end
          if (asrt_done && all_ok) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= '0;
          end
          s_aresetn_q <= 1'b0;
        end
        ST_HOLD: begin
          if (!all_ok) begin
            state_q     <= ST_ASSERT;
            asrt_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            s_aresetn_q <= 1'b0;
          end else if (hold_done) begin
            state_q     <= ST_RUN;
            hold_cnt_q  <= '0;
            s_aresetn_q <= 1'b1;
          end else begin
            hold_cnt_q  <= hold_cnt_q + HCW'(1);
            s_aresetn_q <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!all_ok) begin
            state_q     <= ST_ASSERT;
            asrt_cnt_q  <= '0;
            hold_cnt_q  <= '0;
            s_aresetn_q <= 1'b0;
          end else begin
            s_aresetn_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_ASSERT;
          asrt_cnt_q  <= '0;
          hold_cnt_q  <= '0;
          s_aresetn_q <= 1'b0;
        end
      endcase
    end
  end

  assign s_aresetn = s_aresetn_q;
  assign rst_state = state_q;
  assign rst_cause = cause_q;
  assign rst_count = count_q;

endmodule
